// File: rtl/reservation_station_array_if.sv
// Dispatch/issue/CDB bundle for reservation_station_array.
// master: dispatch + CDB + execution-unit side; slave: the station.
interface reservation_station_array_if #(
  parameter int unsigned NUM_ENTRIES = 4,
  parameter int unsigned TAG_WIDTH   = 7,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned CDB_PORTS   = 2
);
  localparam int unsigned OCC_WIDTH = $clog2(NUM_ENTRIES + 1);

  logic                           alloc_valid;
  logic                           alloc_ready;
  logic [INSTR_WIDTH-1:0]         alloc_instr;
  logic [TAG_WIDTH-1:0]           alloc_rd;
  logic [TAG_WIDTH-1:0]           alloc_rs1;
  logic                           alloc_rs1_ready;
  logic [TAG_WIDTH-1:0]           alloc_rs2;
  logic                           alloc_rs2_ready;
  logic [CDB_PORTS-1:0]           cdb_valid;
  logic [CDB_PORTS*TAG_WIDTH-1:0] cdb_tag;
  logic                           issue_valid;
  logic                           issue_ready;
  logic [INSTR_WIDTH-1:0]         issue_instr;
  logic [TAG_WIDTH-1:0]           issue_rd;
  logic [TAG_WIDTH-1:0]           issue_rs1;
  logic [TAG_WIDTH-1:0]           issue_rs2;
  logic [OCC_WIDTH-1:0]           occupancy;
  logic                           full;
  logic                           empty;

  modport master (
    output alloc_valid, alloc_instr, alloc_rd, alloc_rs1, alloc_rs1_ready,
           alloc_rs2, alloc_rs2_ready, cdb_valid, cdb_tag, issue_ready,
    input  alloc_ready, issue_valid, issue_instr, issue_rd, issue_rs1, issue_rs2,
           occupancy, full, empty
  );

  modport slave (
    input  alloc_valid, alloc_instr, alloc_rd, alloc_rs1, alloc_rs1_ready,
           alloc_rs2, alloc_rs2_ready, cdb_valid, cdb_tag, issue_ready,
    output alloc_ready, issue_valid, issue_instr, issue_rd, issue_rs1, issue_rs2,
           occupancy, full, empty
  );
endinterface

// File: rtl/reservation_station_array.sv
// Multi-entry reservation station: buffers renamed instructions, wakes source
// operands from CDB broadcasts and issues the oldest ready entry.
module reservation_station_array #(
  parameter int unsigned NUM_ENTRIES = 4,
  parameter int unsigned TAG_WIDTH   = 7,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned CDB_PORTS   = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        flush,
  reservation_station_array_if.slave  bus
);
  localparam int unsigned OCC_WIDTH = $clog2(NUM_ENTRIES + 1);

  logic [NUM_ENTRIES-1:0] valid_q;
  logic [NUM_ENTRIES-1:0] rs1_rdy_q;
  logic [NUM_ENTRIES-1:0] rs2_rdy_q;
  logic [INSTR_WIDTH-1:0] instr_q [NUM_ENTRIES];
  logic [TAG_WIDTH-1:0]   rd_q    [NUM_ENTRIES];
  logic [TAG_WIDTH-1:0]   rs1_q   [NUM_ENTRIES];
  logic [TAG_WIDTH-1:0]   rs2_q   [NUM_ENTRIES];
  // older_q[i][j] set: slot i was allocated before slot j
  logic [NUM_ENTRIES-1:0] older_q [NUM_ENTRIES];

  logic [NUM_ENTRIES-1:0] rs1_wake, rs2_wake;
  logic                   alloc_rs1_hit, alloc_rs2_hit;
  logic [NUM_ENTRIES-1:0] alloc_slot;
  logic [NUM_ENTRIES-1:0] cand, issue_sel;
  logic [OCC_WIDTH-1:0]   occ;
  logic                   full, alloc_fire, issue_fire;

  // CDB tag match against stored operands and against the allocating operands
  always_comb begin
    rs1_wake      = '0;
    rs2_wake      = '0;
    alloc_rs1_hit = 1'b0;
    alloc_rs2_hit = 1'b0;
    for (int unsigned p = 0; p < CDB_PORTS; p++) begin
      if (bus.cdb_valid[p]) begin
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
          if (bus.cdb_tag[p*TAG_WIDTH +: TAG_WIDTH] == rs1_q[i]) rs1_wake[i] = 1'b1;
          if (bus.cdb_tag[p*TAG_WIDTH +: TAG_WIDTH] == rs2_q[i]) rs2_wake[i] = 1'b1;
        end
        if (bus.cdb_tag[p*TAG_WIDTH +: TAG_WIDTH] == bus.alloc_rs1) alloc_rs1_hit = 1'b1;
        if (bus.cdb_tag[p*TAG_WIDTH +: TAG_WIDTH] == bus.alloc_rs2) alloc_rs2_hit = 1'b1;
      end
    end
  end

  // Occupancy, status flags and the lowest free slot (one-hot)
  always_comb begin
    occ = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) occ = occ + OCC_WIDTH'(valid_q[i]);
    full       = (occ == OCC_WIDTH'(NUM_ENTRIES));
    alloc_slot = ~valid_q & (valid_q + 1'b1);
    alloc_fire = bus.alloc_valid & ~full;
  end

  // Oldest-ready selection: an entry wins if no older candidate exists
  always_comb begin
    cand = valid_q & rs1_rdy_q & rs2_rdy_q;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      issue_sel[i] = cand[i];
      for (int unsigned j = 0; j < NUM_ENTRIES; j++) begin
        if (j != i && cand[j] && older_q[j][i]) issue_sel[i] = 1'b0;
      end
    end
    issue_fire = (|cand) & bus.issue_ready;
  end

  // Issue mux, zero when nothing is selected
  always_comb begin
    bus.issue_valid = |cand;
    bus.issue_instr = '0;
    bus.issue_rd    = '0;
    bus.issue_rs1   = '0;
    bus.issue_rs2   = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      if (issue_sel[i]) begin
        bus.issue_instr = bus.issue_instr | instr_q[i];
        bus.issue_rd    = bus.issue_rd    | rd_q[i];
        bus.issue_rs1   = bus.issue_rs1   | rs1_q[i];
        bus.issue_rs2   = bus.issue_rs2   | rs2_q[i];
      end
    end
    bus.occupancy   = occ;
    bus.full        = full;
    bus.empty       = (occ == '0);
    bus.alloc_ready = ~full;
  end

  // Entry control state: valid, operand readiness and age ordering
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q   <= '0;
      rs1_rdy_q <= '0;
      rs2_rdy_q <= '0;
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) older_q[i] <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
        if (alloc_fire && alloc_slot[i]) begin
          valid_q[i]   <= 1'b1;
          rs1_rdy_q[i] <= bus.alloc_rs1_ready | alloc_rs1_hit;
          rs2_rdy_q[i] <= bus.alloc_rs2_ready | alloc_rs2_hit;
          older_q[i]   <= '0;
        end else begin
          if (issue_fire && issue_sel[i]) valid_q[i] <= 1'b0;
          rs1_rdy_q[i] <= rs1_rdy_q[i] | rs1_wake[i];
          rs2_rdy_q[i] <= rs2_rdy_q[i] | rs2_wake[i];
          if (alloc_fire) older_q[i] <= older_q[i] | alloc_slot;
        end
      end
    end
  end

  // Payload capture into the allocated slot
  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      if (!reset && !flush && alloc_fire && alloc_slot[i]) begin
        instr_q[i] <= bus.alloc_instr;
        rd_q[i]    <= bus.alloc_rd;
        rs1_q[i]   <= bus.alloc_rs1;
        rs2_q[i]   <= bus.alloc_rs2;
      end
    end
  end
endmodule
